wb_sdram_arbiter: RTL and testbench

- Round-robin Wishbone arbiter that shares the single Wishbone slave port of the SDRAM controller between NUM_M masters (CPU instruction/data, DMA, etc.).
- Sits between the masters and the SDRAM controller Wishbone port, all in the wb_clk domain.
- Holds a grant for the whole Wishbone cycle, so registered bursts (wb_cti_i) stay intact.
- A watchdog terminates a granted cycle with an error if the controller stops acknowledging.

---
 rtl/wb_sdram_arbiter_if.sv | 47 ++++
 rtl/wb_sdram_arbiter.sv | 125 ++++++++++++
 tb/tb_wb_sdram_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sdram_arbiter_if.sv
// Wishbone bundle between NUM_M masters, the round-robin arbiter and the
// single SDRAM controller slave port; the arbiter takes the slave modport.
interface wb_sdram_arbiter_if #(
  parameter int NUM_M = 3,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  // Handshake: stb is the beat-valid and ack/err the beat-ready; a beat
  // completes only in a cycle where stb and ack (or err) are both high,
  // and cyc brackets the whole transfer including idle stb gaps.
  logic [NUM_M*AW-1:0]     m_adr_i;
  logic [NUM_M*DW-1:0]     m_dat_i;
  logic [NUM_M*(DW/8)-1:0] m_sel_i;
  logic [NUM_M-1:0]        m_we_i;
  logic [NUM_M*3-1:0]      m_cti_i;
  logic [NUM_M-1:0]        m_stb_i;
  logic [NUM_M-1:0]        m_cyc_i;
  logic [DW-1:0]           m_dat_o;
  logic [NUM_M-1:0]        m_ack_o;
  logic [NUM_M-1:0]        m_err_o;
  logic [AW-1:0]           s_adr_o;
  logic [DW-1:0]           s_dat_o;
  logic [DW/8-1:0]         s_sel_o;
  logic                    s_we_o;
  logic [2:0]              s_cti_o;
  logic                    s_stb_o;
  logic                    s_cyc_o;
  logic [DW-1:0]           s_dat_i;
  logic                    s_ack_i;
  logic [NUM_M-1:0]        grant_o;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cti_i, m_stb_i, m_cyc_i,
    input  s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_stb_o, s_cyc_o,
    output grant_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cti_i, m_stb_i, m_cyc_i,
    output s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_stb_o, s_cyc_o,
    input  grant_o
  );
endinterface

// File: rtl/wb_sdram_arbiter.sv
// Round-robin Wishbone arbiter in front of the SDRAM controller slave port.
// A grant is held for the whole cyc; a watchdog errors out a stalled slave.
module wb_sdram_arbiter #(
  parameter int NUM_M       = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst,
  wb_sdram_arbiter_if.slave        bus,
  output logic [1:0]               o_state
);
  localparam int GW     = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SW     = DW / 8;
  localparam int WDW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int WD_LIM = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [GW-1:0]    r_gidx, r_last, w_gidx_nxt, w_last_nxt, w_win;
  logic [NUM_M-1:0] r_grant, w_grant_nxt;
  logic [WDW-1:0]   r_wd;
  logic             w_win_vld, w_cyc_g, w_stb_g, w_timeout;
  int               w_idx;

  assign w_cyc_g     = bus.m_cyc_i[r_gidx];
  assign w_stb_g     = bus.m_stb_i[r_gidx];
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.grant_o = r_grant;
  assign o_state     = r_state;

  // Rotating priority: the search starts just after the last winner.
  always_comb begin
    w_win     = '0;
    w_win_vld = 1'b0;
    w_idx     = 0;
    for (int i = 0; i < NUM_M; i++) begin
      w_idx = (int'(r_last) + 1 + i) % NUM_M;
      if (!w_win_vld && bus.m_cyc_i[GW'(w_idx)]) begin
        w_win_vld = 1'b1;
        w_win     = GW'(w_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_last_nxt  = r_last;
    w_timeout   = 1'b0;
    bus.s_adr_o = bus.m_adr_i[int'(r_gidx)*AW +: AW];
    bus.s_dat_o = bus.m_dat_i[int'(r_gidx)*DW +: DW];
    bus.s_sel_o = bus.m_sel_i[int'(r_gidx)*SW +: SW];
    bus.s_we_o  = bus.m_we_i[r_gidx];
    bus.s_cti_o = bus.m_cti_i[int'(r_gidx)*3 +: 3];
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt        = ST_BUSY;
          w_grant_nxt        = '0;
          w_grant_nxt[w_win] = 1'b1;
          w_gidx_nxt         = w_win;
          w_last_nxt         = w_win;
        end
      end
      ST_BUSY: begin
        if (!w_cyc_g) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end else begin
          bus.s_cyc_o         = 1'b1;
          bus.s_stb_o         = w_stb_g;
          bus.m_ack_o[r_gidx] = bus.s_ack_i;
          // An ack on the timeout cycle wins over the error.
          if ((TIMEOUT_CYC > 0) && w_stb_g && !bus.s_ack_i &&
              (r_wd == WDW'(WD_LIM))) begin
            w_timeout           = 1'b1;
            bus.m_err_o[r_gidx] = 1'b1;
            w_state_nxt         = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!w_cyc_g) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= GW'(NUM_M - 1);
      r_wd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_last  <= w_last_nxt;
      if ((r_state == ST_BUSY) && w_cyc_g && w_stb_g && !bus.s_ack_i && !w_timeout)
        r_wd <= r_wd + 1'b1;
      else
        r_wd <= '0;
    end
  end
endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed bench for wb_sdram_arbiter: three masters, watchdog at 16 cycles,
// the bench plays the masters and the SDRAM slave cycle by cycle.
module tb_wb_sdram_arbiter;
  localparam int NUM_M = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT_CYC = 16;

  logic       wb_clk = 1'b0;
  logic       wb_rst;
  logic [1:0] o_state;
  int         n_checks = 0;
  int         n_errors = 0;

  wb_sdram_arbiter_if #(.NUM_M(NUM_M), .AW(AW), .DW(DW)) bus ();

  wb_sdram_arbiter #(.NUM_M(NUM_M), .AW(AW), .DW(DW), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .bus    (bus),
    .o_state(o_state)
  );

  always #5 wb_clk = ~wb_clk;

  // Inputs change 1ns after the edge, outputs are sampled 2ns after it.
  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_m(input int k, input logic we, input logic [AW-1:0] adr,
                         input logic [DW-1:0] dat, input logic [2:0] cti);
    bus.m_cyc_i[k]          = 1'b1;
    bus.m_stb_i[k]          = 1'b1;
    bus.m_we_i[k]           = we;
    bus.m_adr_i[k*AW +: AW] = adr;
    bus.m_dat_i[k*DW +: DW] = dat;
    bus.m_sel_i[k*4 +: 4]   = 4'hF;
    bus.m_cti_i[k*3 +: 3]   = cti;
  endtask

  task automatic drop_m(input int k);
    bus.m_cyc_i[k] = 1'b0;
    bus.m_stb_i[k] = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst = 1'b1;
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0; bus.m_we_i = '0;
    bus.m_cti_i = '0; bus.m_stb_i = '0; bus.m_cyc_i = '0;
    bus.s_dat_i = '0; bus.s_ack_i = 1'b1;
    tick(); tick(); settle();
    n_checks++; if (o_state !== 2'd0) begin n_errors++; $display("FAIL rst_state got=%0d exp=0", o_state); end
    n_checks++; if (bus.grant_o !== 3'b000) begin n_errors++; $display("FAIL rst_grant got=%b exp=000", bus.grant_o); end
    n_checks++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin n_errors++; $display("FAIL rst_cyc_stb got=%b%b exp=00", bus.s_cyc_o, bus.s_stb_o); end
    n_checks++; if (bus.m_ack_o !== 3'b000 || bus.m_err_o !== 3'b000) begin n_errors++; $display("FAIL rst_ack_err got=%b/%b exp=000/000", bus.m_ack_o, bus.m_err_o); end
    bus.s_ack_i = 1'b0;
    wb_rst = 1'b0;
  endtask

  task automatic test_single_write();
    tick();
    drive_m(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'b000);
    settle();
    n_checks++; if (bus.s_cyc_o !== 1'b0 || bus.grant_o !== 3'b000) begin n_errors++; $display("FAIL t1_latency got cyc=%b grant=%b exp cyc=0 grant=000", bus.s_cyc_o, bus.grant_o); end
    tick(); settle();
    n_checks++; if (bus.grant_o !== 3'b001) begin n_errors++; $display("FAIL t1_grant got=%b exp=001", bus.grant_o); end
    n_checks++; if (bus.s_cyc_o !== 1'b1 || bus.s_stb_o !== 1'b1 || bus.s_we_o !== 1'b1) begin n_errors++; $display("FAIL t1_ctrl got cyc=%b stb=%b we=%b exp 1/1/1", bus.s_cyc_o, bus.s_stb_o, bus.s_we_o); end
    n_checks++; if (bus.s_adr_o !== 32'h100 || bus.s_dat_o !== 32'hDEAD_BEEF || bus.s_sel_o !== 4'hF) begin n_errors++; $display("FAIL t1_mux got adr=%h dat=%h sel=%h exp 00000100/deadbeef/f", bus.s_adr_o, bus.s_dat_o, bus.s_sel_o); end
    n_checks++; if (bus.m_ack_o !== 3'b000) begin n_errors++; $display("FAIL t1_early_ack got=%b exp=000", bus.m_ack_o); end
    tick(); tick();
    bus.s_ack_i = 1'b1;
    settle();
    n_checks++; if (bus.m_ack_o !== 3'b001) begin n_errors++; $display("FAIL t1_ack got=%b exp=001", bus.m_ack_o); end
    tick();
    bus.s_ack_i = 1'b0;
    drop_m(0);
    settle();
    n_checks++; if (bus.m_ack_o !== 3'b000 || bus.s_cyc_o !== 1'b0 || bus.grant_o !== 3'b001) begin n_errors++; $display("FAIL t1_drop got ack=%b cyc=%b grant=%b exp 000/0/001", bus.m_ack_o, bus.s_cyc_o, bus.grant_o); end
    tick(); settle();
    n_checks++; if (bus.grant_o !== 3'b000 || o_state !== 2'd0) begin n_errors++; $display("FAIL t1_release got grant=%b state=%0d exp 000/0", bus.grant_o, o_state); end
  endtask

  task automatic test_three_masters();
    logic [2:0]    exp_g;
    logic [DW-1:0] rd;
    wb_rst = 1'b1;
    tick();
    wb_rst = 1'b0;
    for (int k = 0; k < 3; k++) drive_m(k, 1'b0, AW'((k + 1) * 32'h1000), '0, 3'b000);
    settle();
    for (int k = 0; k < 3; k++) begin
      exp_g = 3'b001 << k;
      rd    = 32'hA5A5_0000 | DW'(k);
      tick();
      bus.s_ack_i = 1'b1;
      bus.s_dat_i = rd;
      settle();
      n_checks++; if (bus.grant_o !== exp_g || bus.m_ack_o !== exp_g) begin n_errors++; $display("FAIL t2_grant%0d got grant=%b ack=%b exp %b", k, bus.grant_o, bus.m_ack_o, exp_g); end
      n_checks++; if (bus.m_dat_o !== rd || bus.s_adr_o !== AW'((k + 1) * 32'h1000)) begin n_errors++; $display("FAIL t2_data%0d got dat=%h adr=%h exp %h", k, bus.m_dat_o, bus.s_adr_o, rd); end
      tick();
      bus.s_ack_i = 1'b0;
      drop_m(k);
      tick(); settle();
      n_checks++; if (bus.grant_o !== 3'b000 || bus.s_cyc_o !== 1'b0) begin n_errors++; $display("FAIL t2_gap%0d got grant=%b cyc=%b exp 000/0", k, bus.grant_o, bus.s_cyc_o); end
    end
  endtask

  task automatic test_burst();
    logic [2:0] cti;
    tick();
    drive_m(1, 1'b0, 32'h200, '0, 3'b010);
    settle();
    for (int b = 0; b < 8; b++) begin
      tick();
      cti = (b == 7) ? 3'b111 : 3'b010;
      bus.m_adr_i[AW +: AW] = 32'h200 + AW'(4 * b);
      bus.m_cti_i[3 +: 3]   = cti;
      bus.s_ack_i           = 1'b1;
      if (b == 3) drive_m(2, 1'b0, 32'h300, '0, 3'b000);
      settle();
      n_checks++; if (bus.grant_o !== 3'b010 || bus.m_ack_o !== 3'b010) begin n_errors++; $display("FAIL t3_beat%0d got grant=%b ack=%b exp 010/010", b, bus.grant_o, bus.m_ack_o); end
      n_checks++; if (bus.s_cti_o !== cti || bus.s_adr_o !== 32'h200 + AW'(4 * b)) begin n_errors++; $display("FAIL t3_addr%0d got cti=%b adr=%h exp %b", b, bus.s_cti_o, bus.s_adr_o, cti); end
    end
    tick();
    bus.s_ack_i = 1'b0;
    drop_m(1);
    settle();
    n_checks++; if (bus.grant_o !== 3'b010 || bus.s_cyc_o !== 1'b0) begin n_errors++; $display("FAIL t3_end got grant=%b cyc=%b exp 010/0", bus.grant_o, bus.s_cyc_o); end
    tick(); settle();
    n_checks++; if (bus.grant_o !== 3'b000) begin n_errors++; $display("FAIL t3_idle got=%b exp=000", bus.grant_o); end
    tick();
    bus.s_ack_i = 1'b1;
    settle();
    n_checks++; if (bus.grant_o !== 3'b100 || bus.m_ack_o !== 3'b100 || bus.s_adr_o !== 32'h300) begin n_errors++; $display("FAIL t3_m2 got grant=%b ack=%b adr=%h exp 100/100/300", bus.grant_o, bus.m_ack_o, bus.s_adr_o); end
    tick();
    bus.s_ack_i = 1'b0;
    drop_m(2);
    tick();
  endtask

  task automatic test_fairness();
    int         order[4] = '{0, 2, 0, 2};
    logic [2:0] exp_g;
    drive_m(0, 1'b1, 32'h400, 32'h1, 3'b000);
    drive_m(2, 1'b1, 32'h500, 32'h2, 3'b000);
    settle();
    for (int i = 0; i < 4; i++) begin
      exp_g = 3'b001 << order[i];
      tick();
      bus.s_ack_i = 1'b1;
      settle();
      n_checks++; if (bus.grant_o !== exp_g || bus.m_ack_o !== exp_g) begin n_errors++; $display("FAIL t4_order%0d got grant=%b ack=%b exp %b", i, bus.grant_o, bus.m_ack_o, exp_g); end
      tick();
      bus.s_ack_i = 1'b0;
      drop_m(order[i]);
      tick();
      if (i < 3) drive_m(order[i], 1'b1, 32'h400, 32'h1, 3'b000);
      settle();
      n_checks++; if (bus.grant_o !== 3'b000) begin n_errors++; $display("FAIL t4_gap%0d got=%b exp=000", i, bus.grant_o); end
    end
    drop_m(0);
  endtask

  task automatic test_timeout();
    drive_m(0, 1'b1, 32'h600, 32'h6, 3'b000);
    drive_m(1, 1'b1, 32'h700, 32'h7, 3'b000);
    bus.s_ack_i = 1'b0;
    settle();
    for (int c = 1; c < 16; c++) begin
      tick(); settle();
      n_checks++; if (bus.m_err_o !== 3'b000 || bus.grant_o !== 3'b001) begin n_errors++; $display("FAIL t5_wait%0d got err=%b grant=%b exp 000/001", c, bus.m_err_o, bus.grant_o); end
    end
    tick(); settle();
    n_checks++; if (bus.m_err_o !== 3'b001 || bus.s_cyc_o !== 1'b1 || bus.m_ack_o !== 3'b000) begin n_errors++; $display("FAIL t5_err got err=%b cyc=%b ack=%b exp 001/1/000", bus.m_err_o, bus.s_cyc_o, bus.m_ack_o); end
    tick();
    bus.s_ack_i = 1'b1;
    settle();
    n_checks++; if (o_state !== 2'd2 || bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin n_errors++; $display("FAIL t5_drain got state=%0d cyc=%b stb=%b exp 2/0/0", o_state, bus.s_cyc_o, bus.s_stb_o); end
    n_checks++; if (bus.m_err_o !== 3'b000 || bus.m_ack_o !== 3'b000 || bus.grant_o !== 3'b001) begin n_errors++; $display("FAIL t5_drain_out got err=%b ack=%b grant=%b exp 000/000/001", bus.m_err_o, bus.m_ack_o, bus.grant_o); end
    tick();
    bus.s_ack_i = 1'b0;
    drop_m(0);
    tick(); settle();
    n_checks++; if (bus.grant_o !== 3'b000) begin n_errors++; $display("FAIL t5_idle got=%b exp=000", bus.grant_o); end
    tick();
    bus.s_ack_i = 1'b1;
    settle();
    n_checks++; if (bus.grant_o !== 3'b010 || bus.m_ack_o !== 3'b010) begin n_errors++; $display("FAIL t5_m1 got grant=%b ack=%b exp 010/010", bus.grant_o, bus.m_ack_o); end
    tick();
    bus.s_ack_i = 1'b0;
    drop_m(1);
    tick();
  endtask

  task automatic test_timeout_ack();
    drive_m(0, 1'b0, 32'h800, '0, 3'b000);
    for (int c = 1; c < 16; c++) tick();
    tick();
    bus.s_ack_i = 1'b1;
    settle();
    n_checks++; if (bus.m_ack_o !== 3'b001 || bus.m_err_o !== 3'b000) begin n_errors++; $display("FAIL t7_ack_wins got ack=%b err=%b exp 001/000", bus.m_ack_o, bus.m_err_o); end
    tick();
    bus.s_ack_i = 1'b0;
    settle();
    n_checks++; if (o_state !== 2'd1 || bus.s_cyc_o !== 1'b1) begin n_errors++; $display("FAIL t7_busy got state=%0d cyc=%b exp 1/1", o_state, bus.s_cyc_o); end
    for (int c = 2; c < 16; c++) tick();
    settle();
    n_checks++; if (bus.m_err_o !== 3'b000) begin n_errors++; $display("FAIL t7_cleared15 got=%b exp=000", bus.m_err_o); end
    tick(); settle();
    n_checks++; if (bus.m_err_o !== 3'b001) begin n_errors++; $display("FAIL t7_cleared16 got=%b exp=001", bus.m_err_o); end
    tick();
    drop_m(0);
    tick(); settle();
    n_checks++; if (bus.grant_o !== 3'b000) begin n_errors++; $display("FAIL t7_idle got=%b exp=000", bus.grant_o); end
  endtask

  task automatic test_reset_mid_burst();
    drive_m(2, 1'b0, 32'h900, '0, 3'b010);
    tick();
    bus.s_ack_i = 1'b1;
    settle();
    n_checks++; if (bus.grant_o !== 3'b100 || bus.m_ack_o !== 3'b100) begin n_errors++; $display("FAIL t6_beat got grant=%b ack=%b exp 100/100", bus.grant_o, bus.m_ack_o); end
    tick();
    wb_rst = 1'b1;
    tick();
    wb_rst = 1'b0;
    drive_m(0, 1'b0, 32'hA00, '0, 3'b000);
    settle();
    n_checks++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 || bus.grant_o !== 3'b000) begin n_errors++; $display("FAIL t6_after_rst got cyc=%b stb=%b grant=%b exp 0/0/000", bus.s_cyc_o, bus.s_stb_o, bus.grant_o); end
    n_checks++; if (bus.m_ack_o !== 3'b000 || o_state !== 2'd0) begin n_errors++; $display("FAIL t6_ack_ignored got ack=%b state=%0d exp 000/0", bus.m_ack_o, o_state); end
    bus.s_ack_i = 1'b0;
    tick(); settle();
    n_checks++; if (bus.grant_o !== 3'b001 || bus.s_adr_o !== 32'hA00) begin n_errors++; $display("FAIL t6_m0_first got grant=%b adr=%h exp 001/a00", bus.grant_o, bus.s_adr_o); end
    tick();
    drop_m(0);
    drop_m(2);
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_three_masters();
    test_burst();
    test_fairness();
    test_timeout();
    test_timeout_ack();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
